gamma_pixel_pipe: RTL
=====================

# gamma_pixel_pipe

Two-stage pixel pipeline between `framebuffer_fetch` and the pixel splitters. It takes each fetched RGB565 top/bottom pixel pair, widens every channel to 6 bits and maps it through a loadable 64-entry gamma table. It emits RGB666 pairs that line up with the 6-bit `brightness_mask` bit-plane scan. The table is double-banked: the control path loads the shadow bank, and the swap takes effect only on a frame boundary, so a frame never shows a half-updated curve.

## Interface
Parameters:
- `CHANNEL_BITS`, 6: output bits per colour channel; must equal the brightness bit-plane count. Only 6 is supported.

Ports:
- `clk_in`  in  1  single clock (clk_root domain)
- `reset`  in  1  synchronous, active-high reset
- `pixel_in_valid`  in  1  one-cycle strobe: `rgb565_top_in`/`rgb565_bottom_in` hold a new pair
- `rgb565_top_in`  in  16  {R[4:0],G[5:0],B[4:0]} for the top half
- `rgb565_bottom_in`  in  16  same, for the bottom half
- `bypass`  in  1  1 = output the widened values with no table lookup
- `lut_wr_en`  in  1  write strobe into the shadow bank
- `lut_wr_addr`  in  6  table index
- `lut_wr_data`  in  6  table value
- `lut_swap_req`  in  1  one-cycle request to make the shadow bank active
- `frame_start`  in  1  one-cycle strobe at the start of a frame scan (row 0, column 0)
- `pixel_out_valid`  out  1  output pair valid this cycle
- `rgb666_top_out`  out  18  {R6,G6,B6} for the top half
- `rgb666_bottom_out`  out  18  {R6,G6,B6} for the bottom half
- `lut_swap_pending`  out  1  a swap has been requested and not yet executed

## Operation
- **Widening (stage 1, registered):**
  - R6 = {R5, R5[4]}; B6 = {B5, B5[4]}; G6 = G.
  - Examples: 5'h1F→6'h3F, 5'h10→6'h21, 5'h00→6'h00.
  - The stage-1 valid bit is `pixel_in_valid`, registered.
- **Lookup (stage 2, registered):**
  - Each of the six channel values indexes the active bank: 6 parallel reads.
  - If `bypass` (sampled in the stage-2 cycle) is 1, the stage-1 values pass through unchanged.
  - `pixel_out_valid` is the stage-1 valid bit, registered.
- **Banks:**
  - Two banks, each 64×6 held in flops; `active_bank` is one bit.
  - Lookups always read `bank[active_bank]`.
  - `lut_wr_en` writes `lut_wr_data` to `bank[~active_bank][lut_wr_addr]`. The active bank is never writable.
- **Swap FSM (states IDLE, PENDING):**
  - IDLE + `lut_swap_req` + !`frame_start` → PENDING.
  - PENDING + `frame_start` → toggle `active_bank`, → IDLE.
  - IDLE + `lut_swap_req` + `frame_start` in the same cycle → toggle immediately, stay IDLE.
  - `lut_swap_req` while PENDING is absorbed (no double toggle).
  - `frame_start` in IDLE with no request → no effect.
  - `lut_swap_pending` = (state == PENDING).
- **Reset:**
  - Both banks load identity (entry i = i).
  - `active_bank` = 0; FSM = IDLE; both valid bits = 0.
  - All outputs = 0, including `lut_swap_pending`.
  - A reset mid-frame or mid-swap discards pipeline contents and any pending swap.
- `pixel_in_valid` may be asserted every cycle; there is no backpressure and no stall.

## Timing
- Latency: 2 cycles from a `pixel_in_valid` pair to `pixel_out_valid` carrying the matching data. Throughput is 1 pair per cycle.
- Output data holds its last value while `pixel_out_valid` = 0.
- Write/read ordering:
  - A write at cycle N is visible to lookups only after that bank becomes active.
  - A write on the same cycle as an executing swap lands in the pre-swap shadow bank, i.e. the newly active bank. Software must not do this; the behaviour is defined only for verification.
- Swap takes effect on lookups from cycle N+1, where N is the executing `frame_start` cycle.
  - A pixel in stage 2 during cycle N uses the old bank.
- `frame_start` must be generated ≥2 cycles before the first fetch of the frame is issued, so the whole frame uses a single bank.

## Test plan
- **Reset/identity:** after reset, input top=16'hF81F (R=1F, G=00, B=1F) with valid → two cycles later `pixel_out_valid`=1, top_out=18'h3F03F. Before that cycle, all outputs are 0.
- **Shadow write + swap:**
  - Write entry i = 63−i for all 64 entries, then pulse `lut_swap_req` → `lut_swap_pending`=1, and output still identity.
  - Pulse `frame_start` → pending=0; next input G=6'h05 returns G=6'h3A.
- **Simultaneous request and frame_start:** `lut_swap_req` and `frame_start` in the same cycle from IDLE → bank toggles, `lut_swap_pending` never goes high.
- **Bypass:** with the inverted table active and `bypass`=1, input bottom=16'h8410 → bottom_out = {6'h21,6'h20,6'h21}.
- **Back-to-back stream:** 64 consecutive valid pairs with a swap executing mid-stream → exactly 64 output valids. Pairs whose lookup stage falls at or before the `frame_start` cycle use the old table; later pairs use the new table.
- **Reset mid-operation:** assert `reset` while PENDING with a valid in flight → next cycle pending=0, `pixel_out_valid`=0, tables back to identity.

Source files
------------

// File: rtl/gamma_pixel_pipe.sv
// gamma_pixel_pipe: two-stage RGB565 -> RGB666 pixel pipeline with a
// double-banked 64-entry gamma table. The control path loads the shadow bank.
// The bank swap is deferred to a frame boundary so a frame never mixes curves.
//
// Valid semantics: pixel_in_valid and pixel_out_valid are single-cycle
// qualifiers with no ready/backpressure. A pair is accepted on every cycle
// valid is high. Output data holds its last value while pixel_out_valid is low.
module gamma_pixel_pipe #(
    parameter int CHANNEL_BITS = 6
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        pixel_in_valid,
    input  logic [15:0]                 rgb565_top_in,
    input  logic [15:0]                 rgb565_bottom_in,
    input  logic                        bypass,
    input  logic                        lut_wr_en,
    input  logic [5:0]                  lut_wr_addr,
    input  logic [CHANNEL_BITS-1:0]     lut_wr_data,
    input  logic                        lut_swap_req,
    input  logic                        frame_start,
    output logic                        pixel_out_valid,
    output logic [3*CHANNEL_BITS-1:0]   rgb666_top_out,
    output logic [3*CHANNEL_BITS-1:0]   rgb666_bottom_out,
    output logic                        lut_swap_pending
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    swap_state_t swap_state;
    logic        active_bank;

    logic [CHANNEL_BITS-1:0] bank [0:1][0:63];

    logic                      s1_valid;
    logic [3*CHANNEL_BITS-1:0] s1_top;
    logic [3*CHANNEL_BITS-1:0] s1_bottom;
    logic [3*CHANNEL_BITS-1:0] lut_top;
    logic [3*CHANNEL_BITS-1:0] lut_bottom;

    // 5-bit red/blue channels replicate their MSB into the new LSB so full scale maps to full scale.
    function automatic logic [17:0] widen(input logic [15:0] p);
        return {p[15:11], p[15], p[10:5], p[4:0], p[4]};
    endfunction

    // Stage 1: register the widened pair and its valid bit.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_top    <= '0;
            s1_bottom <= '0;
        end else begin
            s1_valid <= pixel_in_valid;
            if (pixel_in_valid) begin
                s1_top    <= widen(rgb565_top_in);
                s1_bottom <= widen(rgb565_bottom_in);
            end
        end
    end

    // Six parallel reads of the active bank, one per channel of the stage-1 pair.
    always_comb begin
        lut_top    = {bank[active_bank][s1_top[17:12]],
                      bank[active_bank][s1_top[11:6]],
                      bank[active_bank][s1_top[5:0]]};
        lut_bottom = {bank[active_bank][s1_bottom[17:12]],
                      bank[active_bank][s1_bottom[11:6]],
                      bank[active_bank][s1_bottom[5:0]]};
    end

    // Stage 2: register the looked-up (or bypassed) pair; data holds when no valid.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            pixel_out_valid   <= 1'b0;
            rgb666_top_out    <= '0;
            rgb666_bottom_out <= '0;
        end else begin
            pixel_out_valid <= s1_valid;
            if (s1_valid) begin
                rgb666_top_out    <= bypass ? s1_top    : lut_top;
                rgb666_bottom_out <= bypass ? s1_bottom : lut_bottom;
            end
        end
    end

    // Table storage: identity on reset, writes only ever reach the shadow bank.
    // A write in the cycle a swap executes uses the pre-swap active_bank, so it
    // lands in the bank that becomes active.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                bank[0][i] <= CHANNEL_BITS'(i);
                bank[1][i] <= CHANNEL_BITS'(i);
            end
        end else if (lut_wr_en) begin
            bank[~active_bank][lut_wr_addr] <= lut_wr_data;
        end
    end

    // Swap FSM: defer a bank swap request until the next frame_start.
    // Repeated requests while pending are absorbed.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            swap_state       <= IDLE;
            active_bank      <= 1'b0;
            lut_swap_pending <= 1'b0;
        end else begin
            case (swap_state)
                IDLE: begin
                    if (lut_swap_req) begin
                        if (frame_start) begin
                            active_bank <= ~active_bank;
                        end else begin
                            swap_state       <= PENDING;
                            lut_swap_pending <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        active_bank      <= ~active_bank;
                        swap_state       <= IDLE;
                        lut_swap_pending <= 1'b0;
                    end
                end
                default: begin
                    swap_state       <= IDLE;
                    lut_swap_pending <= 1'b0;
                end
            endcase
        end
    end

endmodule
